// File: rtl/jk_ff_bank.sv
// jk_ff_bank: bank of WIDTH independent flip-flops whose run-time mode selects
// JK, D, T or SR behaviour. It also provides parallel load, clock enable,
// per-bit change flags, a sticky SR-illegal error flag and a saturating
// activity counter.
module jk_ff_bank #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] changed,
    output logic             sr_err,
    output logic [CNT_W-1:0] act_cnt
);

    typedef enum logic [1:0] {
        MODE_JK = 2'b00,
        MODE_D  = 2'b01,
        MODE_T  = 2'b10,
        MODE_SR = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] diff;
    logic             err_set;
    mode_e            mode_sel;

    assign mode_sel = mode_e'(mode);
    assign diff     = q_next ^ q;
    assign qbar     = ~q;

    // Next-state selection: load beats enable, otherwise the shared mode picks the per-bit rule
    always_comb begin
        q_next  = q;
        err_set = 1'b0;
        if (load) begin
            q_next = load_val;
        end else if (en) begin
            unique case (mode_sel)
                MODE_JK: q_next = (j & ~q) | (~k & q);
                MODE_D:  q_next = j;
                MODE_T:  q_next = q ^ j;
                MODE_SR: begin
                    // j&k bits hold their value: set on 10, clear on 01, hold on 00 and 11
                    q_next  = (j & ~k) | (q & ~(j ^ k));
                    err_set = |(j & k);
                end
                default: q_next = q;
            endcase
        end
    end

    // State, change flags, sticky error and saturating activity counter all update on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= RST_VAL;
            changed <= '0;
            sr_err  <= 1'b0;
            act_cnt <= '0;
        end else begin
            q       <= q_next;
            changed <= diff;
            if (|diff && act_cnt != CNT_MAX) begin
                act_cnt <= act_cnt + 1'b1;
            end
            if (err_set) begin
                sr_err <= 1'b1;
            end else if (clr_err) begin
                sr_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jk_ff_bank.sv
// Directed testbench for jk_ff_bank: a main instance with RST_VAL=A5 and an
// 8-bit counter, plus a second instance with a 2-bit counter to exercise
// saturation. Both share the same stimulus.
module tb_jk_ff_bank;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] j;
    logic [7:0] k;
    logic       load;
    logic [7:0] load_val;
    logic       clr_err;

    logic [7:0] q;
    logic [7:0] qbar;
    logic [7:0] changed;
    logic       sr_err;
    logic [7:0] act_cnt;

    logic [7:0] s_q;
    logic [7:0] s_qbar;
    logic [7:0] s_changed;
    logic       s_sr_err;
    logic [1:0] s_act_cnt;

    int cmp_cnt  = 0;
    int fail_cnt = 0;

    jk_ff_bank #(.WIDTH(8), .RST_VAL(8'hA5), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
        .load(load), .load_val(load_val), .clr_err(clr_err),
        .q(q), .qbar(qbar), .changed(changed), .sr_err(sr_err), .act_cnt(act_cnt)
    );

    jk_ff_bank #(.WIDTH(8), .RST_VAL(8'hA5), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
        .load(load), .load_val(load_val), .clr_err(clr_err),
        .q(s_q), .qbar(s_qbar), .changed(s_changed), .sr_err(s_sr_err), .act_cnt(s_act_cnt)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive every input for the next edge, then advance one edge and settle
    task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m,
                                 input logic [7:0] jv, input logic [7:0] kv,
                                 input logic ld, input logic [7:0] lv, input logic ce);
        rst      = r;
        en       = e;
        mode     = m;
        j        = jv;
        k        = kv;
        load     = ld;
        load_val = lv;
        clr_err  = ce;
        @(posedge clk);
        #1;
    endtask

    // One comparison: count it, and count and report it if it differs
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; mode = 2'b00; j = '0; k = '0;
        load = 1'b0; load_val = '0; clr_err = 1'b0;
        @(negedge clk);

        // Reset state
        applyStimulus(1, 0, 2'b00, 8'h00, 8'h00, 0, 8'h00, 0);
        checkOutput("rst_q",       32'(q),       32'hA5);
        checkOutput("rst_qbar",    32'(qbar),    32'h5A);
        checkOutput("rst_changed", 32'(changed), 32'h00);
        checkOutput("rst_act",     32'(act_cnt), 32'd0);
        checkOutput("rst_err",     32'(sr_err),  32'd0);

        // JK from A5 with j=F0 k=CC: 7,6 toggle, 5,4 set, 3,2 clear, 1,0 hold
        applyStimulus(0, 1, 2'b00, 8'hF0, 8'hCC, 0, 8'h00, 0);
        checkOutput("jk_q",       32'(q),       32'h71);
        checkOutput("jk_qbar",    32'(qbar),    32'h8E);
        checkOutput("jk_changed", 32'(changed), 32'hD4);
        checkOutput("jk_act",     32'(act_cnt), 32'd1);

        // Load zero with en low; a changing load counts as activity
        applyStimulus(0, 0, 2'b00, 8'h00, 8'h00, 1, 8'h00, 0);
        checkOutput("ld0_q",       32'(q),       32'h00);
        checkOutput("ld0_changed", 32'(changed), 32'h71);
        checkOutput("ld0_act",     32'(act_cnt), 32'd2);

        // T mode, j=FF, four edges
        applyStimulus(0, 1, 2'b10, 8'hFF, 8'h00, 0, 8'h00, 0);
        checkOutput("t1_q", 32'(q), 32'hFF);
        applyStimulus(0, 1, 2'b10, 8'hFF, 8'h00, 0, 8'h00, 0);
        checkOutput("t2_q", 32'(q), 32'h00);
        applyStimulus(0, 1, 2'b10, 8'hFF, 8'h00, 0, 8'h00, 0);
        checkOutput("t3_q", 32'(q), 32'hFF);
        applyStimulus(0, 1, 2'b10, 8'hFF, 8'h00, 0, 8'h00, 0);
        checkOutput("t4_q",       32'(q),       32'h00);
        checkOutput("t4_changed", 32'(changed), 32'hFF);
        checkOutput("t4_act",     32'(act_cnt), 32'd6);

        // en low holds q, clears changed, leaves the counter alone
        applyStimulus(0, 0, 2'b10, 8'hFF, 8'h00, 0, 8'h00, 0);
        checkOutput("hold_q",       32'(q),       32'h00);
        checkOutput("hold_changed", 32'(changed), 32'h00);
        checkOutput("hold_act",     32'(act_cnt), 32'd6);

        // SR j=03 k=01: bit1 set, bit0 illegal -> held, error raised
        applyStimulus(0, 1, 2'b11, 8'h03, 8'h01, 0, 8'h00, 0);
        checkOutput("sr_q",   32'(q),       32'h02);
        checkOutput("sr_err", 32'(sr_err),  32'd1);
        checkOutput("sr_act", 32'(act_cnt), 32'd7);

        // Error is sticky across a clean SR edge without clr_err
        applyStimulus(0, 1, 2'b11, 8'h00, 8'h00, 0, 8'h00, 0);
        checkOutput("sr_sticky", 32'(sr_err), 32'd1);

        // clr_err with no illegal bit clears it
        applyStimulus(0, 1, 2'b11, 8'h00, 8'h00, 0, 8'h00, 1);
        checkOutput("clr_err", 32'(sr_err), 32'd0);
        checkOutput("clr_q",   32'(q),      32'h02);

        // clr_err together with a new illegal bit: set wins
        applyStimulus(0, 1, 2'b11, 8'h01, 8'h01, 0, 8'h00, 1);
        checkOutput("clr_set_err", 32'(sr_err), 32'd1);

        // A load in SR mode with j&k never raises the error; clr_err still clears
        applyStimulus(0, 1, 2'b11, 8'hFF, 8'hFF, 1, 8'h02, 1);
        checkOutput("ldsr_err",     32'(sr_err),  32'd0);
        checkOutput("ldsr_changed", 32'(changed), 32'h00);
        checkOutput("ldsr_act",     32'(act_cnt), 32'd7);

        // SR illegal with en low does nothing
        applyStimulus(0, 0, 2'b11, 8'hFF, 8'hFF, 0, 8'h00, 0);
        checkOutput("sr_en0_err", 32'(sr_err), 32'd0);

        // Load beats en/D mode
        applyStimulus(0, 1, 2'b01, 8'hFF, 8'h00, 1, 8'h3C, 0);
        checkOutput("ldwin_q",       32'(q),       32'h3C);
        checkOutput("ldwin_changed", 32'(changed), 32'h3E);
        checkOutput("ldwin_act",     32'(act_cnt), 32'd8);

        // Reset beats load
        applyStimulus(1, 1, 2'b01, 8'hFF, 8'h00, 1, 8'h3C, 0);
        checkOutput("rstld_q",   32'(q),       32'hA5);
        checkOutput("rstld_act", 32'(act_cnt), 32'd0);

        // First edge after reset acts on RST_VAL: T with j=0F gives AA
        applyStimulus(0, 1, 2'b10, 8'h0F, 8'h00, 0, 8'h00, 0);
        checkOutput("post_rst_q",       32'(q),       32'hAA);
        checkOutput("post_rst_changed", 32'(changed), 32'h0F);

        // Reset mid-toggle sequence discards state
        applyStimulus(1, 1, 2'b10, 8'h0F, 8'h00, 0, 8'h00, 0);
        checkOutput("midrst_q", 32'(q), 32'hA5);

        // D mode alternating 00/FF from A5: every edge changes q
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 2'b01, (i % 2 == 0) ? 8'h00 : 8'hFF, 8'h00, 0, 8'h00, 0);
            if (i == 2) begin
                checkOutput("sat3_small", 32'(s_act_cnt), 32'd3);
            end
        end
        checkOutput("sat_small_act", 32'(s_act_cnt), 32'd3);
        checkOutput("sat_small_q",   32'(s_q),       32'hFF);
        checkOutput("sat_big_act",   32'(act_cnt),   32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
